// File: rtl/fork_join_ctrl.sv
// Fork/join controller: forks one request to NUM_BR branches, joins on first or all
// completions, reports tag, completion mask and latency, then drains late completions.
module fork_join_ctrl #(
  parameter int NUM_BR   = 3,
  parameter int TAG_W    = 8,
  parameter int CNT_W    = 8,
  parameter int JOIN_ANY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [NUM_BR-1:0] br_start,
  input  logic [NUM_BR-1:0] br_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [NUM_BR-1:0] out_mask,
  output logic [CNT_W-1:0]  out_cycles,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FORK,
    S_WAIT,
    S_OUT,
    S_DRAIN
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [NUM_BR-1:0]  acc_mask_q, acc_mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_BR-1:0]  out_mask_q, out_mask_d;
  logic [CNT_W-1:0]   out_cycles_q, out_cycles_d;
  logic               err_q, err_d;

  logic               collecting;
  logic               done_legal;
  logic [NUM_BR-1:0]  nxt_mask;
  logic [CNT_W-1:0]   cnt_inc;
  logic               join_hit;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    tag_d        = tag_q;
    acc_mask_d   = acc_mask_q;
    cnt_d        = cnt_q;
    out_mask_d   = out_mask_q;
    out_cycles_d = out_cycles_q;

    // A done pulse is only honoured while collecting, and only if it repeats no branch.
    collecting = (state_q == S_WAIT) || (state_q == S_OUT) || (state_q == S_DRAIN);
    done_legal = collecting && ((br_done & acc_mask_q) == '0);
    nxt_mask   = done_legal ? (acc_mask_q | br_done) : acc_mask_q;
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    join_hit   = (JOIN_ANY != 0) ? (nxt_mask != '0) : (&nxt_mask);
    err_d      = err_q | ((br_done != '0) && !done_legal);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          tag_d      = in_tag;
          acc_mask_d = '0;
          cnt_d      = '0;
          state_d    = S_FORK;
        end
      end
      S_FORK: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d      = cnt_inc;
        acc_mask_d = nxt_mask;
        if (join_hit) begin
          out_mask_d   = nxt_mask;
          out_cycles_d = cnt_inc;
          state_d      = S_OUT;
        end
      end
      S_OUT: begin
        acc_mask_d = nxt_mask;
        if (out_ready) state_d = (&nxt_mask) ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        acc_mask_d = nxt_mask;
        if (&nxt_mask) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      acc_mask_q   <= '0;
      cnt_q        <= '0;
      out_mask_q   <= '0;
      out_cycles_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      acc_mask_q   <= acc_mask_d;
      cnt_q        <= cnt_d;
      out_mask_q   <= out_mask_d;
      out_cycles_q <= out_cycles_d;
      err_q        <= err_d;
    end
  end

  // All outputs come from flops or from the registered state.
  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign br_start   = {NUM_BR{state_q == S_FORK}};
  assign out_valid  = (state_q == S_OUT);
  assign out_tag    = tag_q;
  assign out_mask   = out_mask_q;
  assign out_cycles = out_cycles_q;
  assign err        = err_q;

endmodule
